dcache_miss_unit: RTL and testbench
===================================

# dcache_miss_unit

Per-port data-cache miss controller for the dual-issue pipeline. On a miss it writes back the dirty victim line as an AXI4 write burst, then refills the line as an AXI4 read burst. During both operations it drives the `stall_miss` and `write_dirty` requests that the hazard unit turns into a whole-pipeline stall. One instance sits between each memory port's cache array and the shared AXI interconnect.

## Interface
- `ADDR_W`, 64, physical address width.
- `DATA_W`, 64, AXI data width in bits.
- `LINE_BYTES`, 64, cache line size. `BEATS = LINE_BYTES*8/DATA_W` (8 by default); must be a power of two ≤ 256.
- `AXI_ID`, 0, constant value driven on `awid`/`arid`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `miss_req` in 1: the cache reports a miss. Held high until `refill_valid`.
- `miss_addr` in ADDR_W: missing address; low log2(LINE_BYTES) bits are ignored.
- `miss_dirty` in 1: the victim line is dirty and needs writeback.
- `victim_addr` in ADDR_W: line address of the victim.
- `victim_line` in LINE_BYTES*8: victim data, stable while `miss_req` is high.
- `refill_valid` out 1: one-cycle pulse; `refill_line` is complete.
- `refill_line` out LINE_BYTES*8: fetched line, beat 0 in the LSBs.
- `stall_miss` out 1: stall request to the hazard unit.
- `write_dirty` out 1: writeback in progress; stall request to the hazard unit.
- `bus_err` out 1: sticky error flag. Exists only with `DCACHE_BUS_ERR_EN`.
- AXI4 AW: `awid awaddr awlen awsize awburst awvalid` out, `awready` in.
- AXI4 W: `wdata wstrb wlast wvalid` out, `wready` in.
- AXI4 B: `bresp bvalid` in, `bready` out.
- AXI4 AR: `arid araddr arlen arsize arburst arvalid` out, `arready` in.
- AXI4 R: `rdata rresp rlast rvalid` in, `rready` out.

## Operation
- The state machine has seven states: IDLE, WB_AW, WB_W, WB_B, RD_AR, RD_R, DONE.
- IDLE:
  - `miss_req & miss_dirty` → WB_AW.
  - `miss_req & ~miss_dirty` → RD_AR.
  - The victim line, victim address and miss address are captured on the transition, so later input changes have no effect.
- WB_AW: `awvalid=1`, `awaddr` = line-aligned victim address. On `awready` → WB_W.
- WB_W:
  - `wvalid=1`, `wdata` = captured beat[cnt], `wstrb` all ones.
  - `wlast = (cnt==BEATS-1)`.
  - `cnt` advances on `wready`.
  - On the last handshake → WB_B.
- WB_B: `bready=1`. On `bvalid` → RD_AR.
- RD_AR: `arvalid=1`, `araddr` = line-aligned miss address. On `arready` → RD_R.
- RD_R:
  - `rready=1`.
  - Each `rvalid` beat writes `rdata` into line slot `cnt`, then `cnt++`.
  - The beat where `cnt==BEATS-1` → DONE. `rlast` does not affect sequencing.
- DONE: `refill_valid=1` for exactly one cycle, then → IDLE.
- Constant burst fields:
  - `awlen = arlen = BEATS-1`.
  - `awsize = arsize = log2(DATA_W/8)`.
  - `awburst = arburst = INCR`.
- `stall_miss = miss_req | (state != IDLE)`. This is combinational, so the pipeline stalls in the same cycle the miss is raised. It is low in the cycle after DONE.
- `write_dirty` is high in WB_AW, WB_W and WB_B.
- `cnt` is log2(BEATS)+1 bits and clears on every state entry. It never wraps mid-burst.
- `miss_req` is ignored outside IDLE. The cycle after DONE is IDLE, so the cache must have dropped `miss_req` by then; if `miss_req` is still high, a new miss starts.

## Timing
- Reset values:
  - State is IDLE.
  - All `*valid` and `*ready` outputs, `wlast`, `refill_valid`, `write_dirty` and `bus_err` are 0.
  - `refill_line` and `cnt` are 0.
- An asynchronous reset in any state abandons the burst immediately; no AXI completion is attempted.
- Every AXI `valid`, once asserted, stays high with stable payload until its `ready`.
- Minimum clean-miss latency, with ready always high: AR (1 cycle) + BEATS R cycles + DONE.
  - The refill pulses on cycle BEATS+2 after `miss_req`; 10 cycles for the default configuration.
- Minimum dirty-miss latency: adds 1 (AW) + BEATS (W) + 1 (B) cycles; 20 cycles for the default configuration.
- `refill_line` holds its value from DONE until the next refill's first R beat.

## Configuration
- `DCACHE_BUS_ERR_EN` defined:
  - `bus_err` is set when a `bresp` or `rresp` is non-OKAY, or `rlast` is wrong for the beat position. It clears only on reset.
  - Sequencing is unchanged.
- `DCACHE_BUS_ERR_EN` undefined: the `bus_err` port and its logic are absent, and `bresp`/`rresp` are unused.

## Structure
- Shared package `cache_pkg`:
  - The state enum.
  - AXI burst/resp constants (`AXI_BURST_INCR`, `AXI_RESP_OKAY`).
  - The `BEATS` / `OFFSET_W` derivation functions.
- One natural sub-module, `axi_line_buffer`: a LINE_BYTES×8 register, written one beat at a time by index and read out one beat at a time by index. It serves both the writeback capture and the refill assembly.

## Test plan
- Clean miss, all ready=1, `miss_addr=0x1000_0028`:
  - `araddr=0x1000_0000`, `arlen=7`.
  - `refill_valid` pulses 10 cycles later with beats 0–7 in order.
  - `write_dirty` stays 0.
- Dirty miss, `victim_addr=0x2000_0040`:
  - AW is issued at `0x2000_0040`, then 8 W beats with `wlast` only on beat 7, then B, then AR.
  - `write_dirty` is high for exactly 10 cycles.
- Back-pressure: `awready`, `wready`, `arready` and `rvalid` randomly low for up to 5 cycles:
  - Payloads stay stable while valid is high.
  - No beat is duplicated or dropped.
  - `stall_miss` is high throughout.
- `miss_addr`/`victim_line` change after IDLE capture → the written and fetched data match the captured values.
- `reset` pulsed low mid-WB_W → all outputs drop to reset values asynchronously. A following clean miss completes normally.
- With `DCACHE_BUS_ERR_EN`: `rresp=SLVERR` on beat 3 → `bus_err` goes to 1 and stays 1, and `refill_valid` still pulses after beat 7.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the data-cache miss path: FSM states, AXI burst/resp codes,
// and helpers that derive beat count and line offset width from the cache geometry.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB_AW,
    WB_W,
    WB_B,
    RD_AR,
    RD_R,
    DONE
  } miss_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic int calc_beats(input int line_bytes, input int data_w);
    return (line_bytes * 8) / data_w;
  endfunction

  function automatic int calc_offset_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

endpackage

// File: rtl/axi_line_buffer.sv
// One cache line of storage: whole-line load or single-beat write by index, single-beat read by index.
// Writes land on the next clock edge; reads are combinational; there is no flow control.
module axi_line_buffer #(
  parameter int DATA_W = 64,
  parameter int BEATS  = 8,
  parameter int IDX_W  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [BEATS*DATA_W-1:0] load_line,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [DATA_W-1:0]       wr_dat,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [DATA_W-1:0]       rd_dat,
  output logic [BEATS*DATA_W-1:0] line
);

  logic [BEATS-1:0][DATA_W-1:0] mem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem <= '0;
    end else if (load) begin
      mem <= load_line;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_idx];
  assign line   = mem;

endmodule

// File: rtl/dcache_miss_unit.sv
// Per-port D-cache miss controller: optional dirty-victim AXI write burst, then AXI read refill.
// Clean miss refills in BEATS+2 cycles; every AXI valid holds until ready. DCACHE_BUS_ERR_EN adds bus_err.
module dcache_miss_unit
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int LINE_BYTES = 64,
  parameter int AXI_ID     = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    miss_req,
  input  logic [ADDR_W-1:0]       miss_addr,
  input  logic                    miss_dirty,
  input  logic [ADDR_W-1:0]       victim_addr,
  input  logic [LINE_BYTES*8-1:0] victim_line,
  output logic                    refill_valid,
  output logic [LINE_BYTES*8-1:0] refill_line,
  output logic                    stall_miss,
  output logic                    write_dirty,
`ifdef DCACHE_BUS_ERR_EN
  output logic                    bus_err,
`endif
  output logic [3:0]              awid,
  output logic [ADDR_W-1:0]       awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_W-1:0]       wdata,
  output logic [DATA_W/8-1:0]     wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [3:0]              arid,
  output logic [ADDR_W-1:0]       araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_W-1:0]       rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam int BEATS    = calc_beats(LINE_BYTES, DATA_W);
  localparam int OFFSET_W = calc_offset_w(LINE_BYTES);
  localparam int IDX_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W    = IDX_W + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFFSET_W) - ADDR_W'(1));

  miss_state_e       state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [ADDR_W-1:0] ar_addr_q;
  logic              capture;
  logic              refill_wr;
  logic [LINE_BYTES*8-1:0] unused_wb_line;
  logic [DATA_W-1:0]       unused_rf_beat;

  assign capture   = (state == IDLE) && miss_req;
  assign refill_wr = (state == RD_R) && rvalid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      aw_addr_q    <= '0;
      ar_addr_q    <= '0;
      awvalid      <= 1'b0;
      wvalid       <= 1'b0;
      wlast        <= 1'b0;
      bready       <= 1'b0;
      arvalid      <= 1'b0;
      rready       <= 1'b0;
      refill_valid <= 1'b0;
      write_dirty  <= 1'b0;
    end else begin
      refill_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (miss_req) begin
            aw_addr_q <= victim_addr & LINE_MASK;
            ar_addr_q <= miss_addr & LINE_MASK;
            cnt       <= '0;
            if (miss_dirty) begin
              state       <= WB_AW;
              awvalid     <= 1'b1;
              write_dirty <= 1'b1;
            end else begin
              state   <= RD_AR;
              arvalid <= 1'b1;
            end
          end
        end
        WB_AW: begin
          if (awready) begin
            state   <= WB_W;
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            wlast   <= (BEATS == 1);
            cnt     <= '0;
          end
        end
        WB_W: begin
          if (wready) begin
            if (cnt == LAST_CNT) begin
              state  <= WB_B;
              wvalid <= 1'b0;
              wlast  <= 1'b0;
              bready <= 1'b1;
              cnt    <= '0;
            end else begin
              cnt   <= cnt + CNT_W'(1);
              wlast <= ((cnt + CNT_W'(1)) == LAST_CNT);
            end
          end
        end
        WB_B: begin
          if (bvalid) begin
            state       <= RD_AR;
            bready      <= 1'b0;
            write_dirty <= 1'b0;
            arvalid     <= 1'b1;
            cnt         <= '0;
          end
        end
        RD_AR: begin
          if (arready) begin
            state   <= RD_R;
            arvalid <= 1'b0;
            rready  <= 1'b1;
            cnt     <= '0;
          end
        end
        RD_R: begin
          // rlast is deliberately ignored: the beat counter alone ends the burst
          if (rvalid) begin
            if (cnt == LAST_CNT) begin
              state        <= DONE;
              rready       <= 1'b0;
              refill_valid <= 1'b1;
              cnt          <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign stall_miss = miss_req | (state != IDLE);

  assign awid    = 4'(AXI_ID);
  assign arid    = 4'(AXI_ID);
  assign awaddr  = aw_addr_q;
  assign araddr  = ar_addr_q;
  assign awlen   = 8'(BEATS - 1);
  assign arlen   = 8'(BEATS - 1);
  assign awsize  = 3'($clog2(DATA_W / 8));
  assign arsize  = 3'($clog2(DATA_W / 8));
  assign awburst = AXI_BURST_INCR;
  assign arburst = AXI_BURST_INCR;
  assign wstrb   = '1;

  // Separate buffers so a new victim capture never disturbs the last refilled line
  axi_line_buffer #(.DATA_W(DATA_W), .BEATS(BEATS), .IDX_W(IDX_W)) u_wb_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (capture),
    .load_line (victim_line),
    .wr_en     (1'b0),
    .wr_idx    ('0),
    .wr_dat    ('0),
    .rd_idx    (cnt[IDX_W-1:0]),
    .rd_dat    (wdata),
    .line      (unused_wb_line)
  );

  axi_line_buffer #(.DATA_W(DATA_W), .BEATS(BEATS), .IDX_W(IDX_W)) u_rf_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (1'b0),
    .load_line ('0),
    .wr_en     (refill_wr),
    .wr_idx    (cnt[IDX_W-1:0]),
    .wr_dat    (rdata),
    .rd_idx    ('0),
    .rd_dat    (unused_rf_beat),
    .line      (refill_line)
  );

`ifdef DCACHE_BUS_ERR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_err <= 1'b0;
    end else if ((bvalid && bready && (bresp != AXI_RESP_OKAY)) ||
                 (rvalid && rready && ((rresp != AXI_RESP_OKAY) || (rlast != (cnt == LAST_CNT))))) begin
      bus_err <= 1'b1;
    end
  end
`else
  logic unused_resp;
  assign unused_resp = ^{bresp, rresp, rlast};
`endif

endmodule

// File: tb/tb_dcache_miss_unit.sv
// Directed bench for dcache_miss_unit: clean/dirty misses, back-pressure, input capture and async reset.
module tb_dcache_miss_unit;

  localparam int BEATS = 8;
  localparam int LW    = 512;

  logic          clk = 1'b0;
  logic          reset;
  logic          miss_req;
  logic [63:0]   miss_addr;
  logic          miss_dirty;
  logic [63:0]   victim_addr;
  logic [LW-1:0] victim_line;
  logic          refill_valid;
  logic [LW-1:0] refill_line;
  logic          stall_miss;
  logic          write_dirty;
`ifdef DCACHE_BUS_ERR_EN
  logic          bus_err;
`endif
  logic [3:0]    awid, arid;
  logic [63:0]   awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst;
  logic          awvalid, awready;
  logic [63:0]   wdata;
  logic [7:0]    wstrb;
  logic          wlast, wvalid, wready;
  logic [1:0]    bresp;
  logic          bvalid, bready;
  logic          arvalid, arready;
  logic [63:0]   rdata;
  logic [1:0]    rresp;
  logic          rlast, rvalid, rready;

  always #5 clk = ~clk;

  dcache_miss_unit dut (
    .clk(clk), .reset(reset),
    .miss_req(miss_req), .miss_addr(miss_addr), .miss_dirty(miss_dirty),
    .victim_addr(victim_addr), .victim_line(victim_line),
    .refill_valid(refill_valid), .refill_line(refill_line),
    .stall_miss(stall_miss), .write_dirty(write_dirty),
`ifdef DCACHE_BUS_ERR_EN
    .bus_err(bus_err),
`endif
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int errs   = 0;
  int checks = 0;
  bit bp_mode = 1'b0;
  int lo_run [4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] vl_beat(input logic [7:0] seed, input int i);
    return {8'hA0, 40'h0, seed, 8'(i)};
  endfunction

  function automatic logic [63:0] rd_beat(input logic [7:0] seed, input int i);
    return {8'hD0, 40'h0, seed, 8'(i)};
  endfunction

  // Ready/valid chooser: random lows in back-pressure mode, never more than 5 in a row
  function automatic logic pick(input int k);
    if (!bp_mode || lo_run[k] >= 5 || $urandom_range(0, 2) != 0) begin
      lo_run[k] = 0;
      return 1'b1;
    end
    lo_run[k]++;
    return 1'b0;
  endfunction

  task automatic run_txn(input string name, input bit dirty, input bit bp, input bit scramble,
                         input logic [63:0] maddr, input logic [63:0] vaddr,
                         input logic [7:0] seed, input int err_beat);
    logic [63:0] w_dat [BEATS];
    logic [7:0]  wlast_mask;
    int          aw_n, w_n, ar_n, r_n, lat, wd_n, stall_lo, stab, strb_bad;
    logic [63:0] aw_addr_rec, ar_addr_rec, aw_held, w_held, ar_held;
    logic [7:0]  aw_len_rec, ar_len_rec;
    logic [2:0]  ar_size_rec;
    logic [1:0]  ar_burst_rec;
    logic [3:0]  ar_id_rec;
    bit          aw_hold, w_hold, ar_hold, done;
    logic [LW-1:0] got;
    wlast_mask = '0; aw_n = 0; w_n = 0; ar_n = 0; r_n = 0; lat = 0; wd_n = 0;
    stall_lo = 0; stab = 0; strb_bad = 0; aw_hold = 0; w_hold = 0; ar_hold = 0; done = 0;
    aw_addr_rec = '0; ar_addr_rec = '0; aw_held = '0; w_held = '0; ar_held = '0;
    aw_len_rec = '0; ar_len_rec = '0; ar_size_rec = '0; ar_burst_rec = '0; ar_id_rec = '1;
    got = '0;
    bp_mode = bp;
    miss_addr = maddr; victim_addr = vaddr; miss_dirty = dirty;
    for (int i = 0; i < BEATS; i++) begin
      victim_line[i*64 +: 64] = vl_beat(seed, i);
      w_dat[i] = '0;
    end
    miss_req = 1'b1;
    while (!done && lat < 400) begin
      @(negedge clk);
      lat++;
      if (scramble && lat == 1) begin
        miss_addr = ~maddr; victim_addr = ~vaddr; victim_line = ~victim_line; miss_dirty = ~dirty;
      end
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rlast = 0; rresp = 0; bresp = 0;
      if (refill_valid) begin
        done = 1; got = refill_line; miss_req = 1'b0;
      end else begin
        if (!stall_miss) stall_lo++;
        if (write_dirty) wd_n++;
        awready = pick(0); wready = pick(1); arready = pick(2);
        bvalid = bready;
        if (rready && pick(3)) begin
          rvalid = 1'b1;
          rdata  = rd_beat(seed, r_n);
          rlast  = (r_n == BEATS - 1);
          rresp  = (r_n == err_beat) ? 2'b10 : 2'b00;
        end
        if (aw_hold && (!awvalid || awaddr !== aw_held)) stab++;
        if (awvalid && awready) begin
          aw_n++; aw_addr_rec = awaddr; aw_len_rec = awlen; aw_hold = 0;
        end else begin
          aw_hold = awvalid; aw_held = awaddr;
        end
        if (w_hold && (!wvalid || wdata !== w_held)) stab++;
        if (wvalid && wready) begin
          if (w_n < BEATS) begin
            w_dat[w_n] = wdata;
            if (wlast) wlast_mask[w_n] = 1'b1;
          end
          if (wstrb !== 8'hFF) strb_bad++;
          w_n++; w_hold = 0;
        end else begin
          w_hold = wvalid; w_held = wdata;
        end
        if (ar_hold && (!arvalid || araddr !== ar_held)) stab++;
        if (arvalid && arready) begin
          ar_n++; ar_addr_rec = araddr; ar_len_rec = arlen; ar_size_rec = arsize;
          ar_burst_rec = arburst; ar_id_rec = arid; ar_hold = 0;
        end else begin
          ar_hold = arvalid; ar_held = araddr;
        end
        if (rvalid && rready) r_n++;
      end
    end
    check({name, ".done"}, 64'(done), 64'd1);
    if (!bp) begin
      check({name, ".latency"}, 64'(lat), dirty ? 64'd20 : 64'd10);
      check({name, ".write_dirty_cycles"}, 64'(wd_n), dirty ? 64'd10 : 64'd0);
    end
    check({name, ".aw_count"}, 64'(aw_n), dirty ? 64'd1 : 64'd0);
    check({name, ".w_count"}, 64'(w_n), dirty ? 64'd8 : 64'd0);
    if (dirty) begin
      check({name, ".awaddr"}, aw_addr_rec, vaddr & ~64'h3F);
      check({name, ".awlen"}, 64'(aw_len_rec), 64'd7);
      check({name, ".wlast_mask"}, 64'(wlast_mask), 64'h80);
      check({name, ".wstrb_bad"}, 64'(strb_bad), 64'd0);
      for (int i = 0; i < BEATS; i++)
        check($sformatf("%s.wdata%0d", name, i), w_dat[i], vl_beat(seed, i));
    end
    check({name, ".ar_count"}, 64'(ar_n), 64'd1);
    check({name, ".araddr"}, ar_addr_rec, maddr & ~64'h3F);
    check({name, ".arlen"}, 64'(ar_len_rec), 64'd7);
    check({name, ".arsize"}, 64'(ar_size_rec), 64'd3);
    check({name, ".arburst"}, 64'(ar_burst_rec), 64'd1);
    check({name, ".arid"}, 64'(ar_id_rec), 64'd0);
    check({name, ".stall_low"}, 64'(stall_lo), 64'd0);
    check({name, ".unstable"}, 64'(stab), 64'd0);
    for (int i = 0; i < BEATS; i++)
      check($sformatf("%s.refill%0d", name, i), got[i*64 +: 64], rd_beat(seed, i));
    @(negedge clk);
    check({name, ".stall_after"}, 64'(stall_miss), 64'd0);
    check({name, ".pulse_once"}, 64'(refill_valid), 64'd0);
    check({name, ".refill_hold"}, refill_line[63:0], rd_beat(seed, 0));
  endtask

  initial begin
    reset = 1'b1; miss_req = 0; miss_addr = '0; miss_dirty = 0; victim_addr = '0; victim_line = '0;
    awready = 0; wready = 0; bresp = 0; bvalid = 0; arready = 0; rdata = '0; rresp = 0; rlast = 0; rvalid = 0;
    #1 reset = 1'b0;
    #1;
    check("rst.awvalid", 64'(awvalid), 64'd0);
    check("rst.wvalid", 64'(wvalid), 64'd0);
    check("rst.arvalid", 64'(arvalid), 64'd0);
    check("rst.readies", 64'({bready, rready}), 64'd0);
    check("rst.wlast", 64'(wlast), 64'd0);
    check("rst.refill_valid", 64'(refill_valid), 64'd0);
    check("rst.write_dirty", 64'(write_dirty), 64'd0);
    check("rst.stall_miss", 64'(stall_miss), 64'd0);
    check("rst.refill_line", refill_line[63:0], 64'd0);
`ifdef DCACHE_BUS_ERR_EN
    check("rst.bus_err", 64'(bus_err), 64'd0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_txn("clean",    1'b0, 1'b0, 1'b0, 64'h1000_0028, 64'h0,          8'h11, -1);
    run_txn("dirty",    1'b1, 1'b0, 1'b0, 64'h3000_0010, 64'h2000_0040, 8'h22, -1);
    run_txn("bp_dirty", 1'b1, 1'b1, 1'b0, 64'h3000_1234, 64'h2000_07C0, 8'h33, -1);
    run_txn("bp_clean", 1'b0, 1'b1, 1'b0, 64'h1000_0FFF, 64'h0,          8'h44, -1);
    run_txn("capture",  1'b1, 1'b0, 1'b1, 64'h6000_0048, 64'h7000_0100, 8'h55, -1);

    // Async reset in the middle of the writeback burst
    miss_addr = 64'h4000_0000; victim_addr = 64'h5000_0080; miss_dirty = 1'b1;
    awready = 1; wready = 1; arready = 1; bvalid = 0; rvalid = 0;
    miss_req = 1'b1;
    repeat (4) @(negedge clk);
    check("mid.wvalid", 64'(wvalid), 64'd1);
    miss_req = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("mid_rst.wvalid", 64'(wvalid), 64'd0);
    check("mid_rst.write_dirty", 64'(write_dirty), 64'd0);
    check("mid_rst.valids", 64'({awvalid, arvalid, wlast}), 64'd0);
    check("mid_rst.readies", 64'({bready, rready}), 64'd0);
    check("mid_rst.stall_miss", 64'(stall_miss), 64'd0);
    check("mid_rst.refill_lo", refill_line[63:0], 64'd0);
    check("mid_rst.refill_hi", refill_line[511:448], 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_txn("post_rst", 1'b0, 1'b0, 1'b0, 64'h1000_0080, 64'h0, 8'h66, -1);

`ifdef DCACHE_BUS_ERR_EN
    check("berr.before", 64'(bus_err), 64'd0);
    run_txn("berr", 1'b0, 1'b0, 1'b0, 64'h1000_0200, 64'h0, 8'h77, 3);
    check("berr.set", 64'(bus_err), 64'd1);
    run_txn("berr2", 1'b0, 1'b0, 1'b0, 64'h1000_0300, 64'h0, 8'h88, -1);
    check("berr.sticky", 64'(bus_err), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
